// File: rtl/btb_next_pc.sv
// Direct-mapped BTB with 2-bit saturating counters and the next-PC select
// feeding the PC register; trains from EX resolutions.
module btb_next_pc #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic        pred_taken_q,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRIES-1:0][31:0]       r_target;
  logic [ENTRIES-1:0][1:0]        r_ctr;

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_up_hit;
  logic [1:0]       w_ctr_cur, w_ctr_nxt;

  assign w_lk_idx = pc_in[IDX_W+1:2];
  assign w_lk_tag = pc_in[31:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  // Lookup sees pre-update contents; no bypass from a same-cycle update.
  assign pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];

  always_comb begin
    next_pc = pc_in + 32'd4;
    if (mispredict)      next_pc = redirect_pc;
    else if (pred_taken) next_pc = r_target[w_lk_idx];
  end

  assign w_up_idx  = upd_pc[IDX_W+1:2];
  assign w_up_tag  = upd_pc[31:IDX_W+2];
  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_ctr_cur = r_ctr[w_up_idx];

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_ctr    <= '0;
      r_tag    <= '0;
      r_target <= '0;
    end else if (upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_nxt;
        if (upd_taken) r_target[w_up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Miss on a taken branch: allocate weakly-taken, replacing any alias.
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_taken_q     <= 1'b0;
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (mispredict)  pred_taken_q <= 1'b0;
      else if (!stall) pred_taken_q <= pred_taken;
      if (!stall)      stat_lookups     <= stat_lookups + 32'd1;
      if (mispredict)  stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench: directed cases then random traffic against a table model.
module tb_btb_next_pc;
  logic        clk = 1'b0;
  logic        rst, stall, mispredict, upd_valid, upd_taken;
  logic [31:0] pc_in, redirect_pc, upd_pc, upd_target;
  logic [31:0] next_pc, stat_lookups, stat_mispredicts;
  logic        pred_taken, pred_taken_q;

  btb_next_pc dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .stall(stall), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .next_pc(next_pc),
    .pred_taken(pred_taken), .pred_taken_q(pred_taken_q),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference table: plain arrays indexed by pc[5:2], tag is pc>>6.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_ptq, m_known = 0;
  logic [31:0] m_lk, m_mp;

  logic [31:0] o_npc, o_lk, o_mp;
  logic        o_pt, o_ptq;

  task automatic cycle(input bit r, input logic [31:0] pc, input bit st,
                       input bit mp, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt);
    int idx, uidx;
    bit hit, pt, uhit;
    logic [31:0] npc;
    rst = r; pc_in = pc; stall = st; mispredict = mp; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    #1;
    idx = int'((pc >> 2) % 16);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
    pt  = hit && (m_ctr[idx] >= 2);
    npc = mp ? rpc : (pt ? m_tgt[idx] : pc + 32'd4);
    o_npc = next_pc; o_pt = pred_taken; o_ptq = pred_taken_q;
    o_lk = stat_lookups; o_mp = stat_mispredicts;
    if (m_known) begin
      chk("next_pc", next_pc, npc);
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
      chk("pred_taken_q", {31'b0, pred_taken_q}, {31'b0, m_ptq});
      chk("stat_lookups", stat_lookups, m_lk);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
      m_ptq = 0; m_lk = 0; m_mp = 0; m_known = 1;
    end else begin
      if (mp) m_ptq = 0; else if (!st) m_ptq = pt;
      if (!st) m_lk = m_lk + 1;
      if (mp)  m_mp = m_mp + 1;
      if (uv) begin
        uidx = int'((upc >> 2) % 16);
        uhit = m_valid[uidx] && (m_tag[uidx] == upc[31:6]);
        if (uhit) begin
          m_ctr[uidx] = ut ? ((m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3)
                           : ((m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0);
          if (ut) m_tgt[uidx] = utgt;
        end else if (ut) begin
          m_valid[uidx] = 1; m_tag[uidx] = upc[31:6]; m_tgt[uidx] = utgt; m_ctr[uidx] = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(0, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    cycle(0, 32'h100, 0, 0, 0, 1, upc, ut, utgt);
  endtask

  logic [31:0] lk0, mp0, pc;
  bit          ptq0;

  initial begin
    rst = 1; pc_in = 0; stall = 0; mispredict = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

    look(32'h100);
    chk("tp_reset_npc", o_npc, 32'h104);
    chk("tp_reset_pt", {31'b0, o_pt}, 0);
    chk("tp_reset_ptq", {31'b0, o_ptq}, 0);
    chk("tp_reset_lk", o_lk, 0);
    chk("tp_reset_mp", o_mp, 0);

    cycle(0, 32'h40, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    chk("tp_nobypass", o_npc, 32'h44);
    look(32'h40);
    chk("tp_alloc_npc", o_npc, 32'h80);
    chk("tp_alloc_pt", {31'b0, o_pt}, 1);

    upd(32'h40, 0, 0); upd(32'h40, 0, 0);
    look(32'h40);
    chk("tp_ctr00", o_npc, 32'h44);
    upd(32'h40, 1, 32'h80); upd(32'h40, 1, 32'h80); upd(32'h40, 1, 32'h80);
    upd(32'h40, 0, 0);
    look(32'h40);
    chk("tp_sat_hyst", o_npc, 32'h80);

    look(32'h80);
    chk("tp_alias_npc", o_npc, 32'h84);
    upd(32'h80, 0, 0);
    look(32'h40);
    chk("tp_alias_keep", o_npc, 32'h80);

    lk0 = o_lk + 1; mp0 = o_mp;
    cycle(0, 32'h40, 1, 1, 32'h200, 0, 0, 0, 0);
    chk("tp_mp_npc", o_npc, 32'h200);
    chk("tp_mp_pt", {31'b0, o_pt}, 1);
    look(32'h100);
    chk("tp_mp_ptq", {31'b0, o_ptq}, 0);
    chk("tp_mp_cnt", o_mp, mp0 + 1);
    chk("tp_mp_lk", o_lk, lk0);

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    look(32'hFFFF_FFFC);
    chk("tp_wrap", o_npc, 32'h0);
    upd(32'h40, 1, 32'h80);
    look(32'h40);
    lk0 = o_lk + 1; ptq0 = 1;
    for (int i = 0; i < 3; i++) cycle(0, 32'h100, 1, 0, 0, 0, 0, 0, 0);
    look(32'h100);
    chk("tp_stall_ptq", {31'b0, o_ptq}, {31'b0, ptq0});
    chk("tp_stall_lk", o_lk, lk0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
      else pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      cycle($urandom_range(0, 199) == 0, pc, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
            $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
- Branch target buffer plus next-PC selector: the stage directly upstream of the program counter register; its next_pc drives the PC's new-PC input.
- Each cycle it looks up the current PC in a direct-mapped BTB with 2-bit saturating counters and chooses among the predicted target, sequential PC+4 and the EX-stage redirect.
- Trains from branch/jump resolutions reported by EX.
- Registers the prediction bit so it travels with the fetched instruction into IF/ID.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 4..64
IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2]
TAG_W, 26, 30-IDX_W; tag = pc[31:IDX_W+2]

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
pc_in  input  32  current PC (output of PC register)
stall  input  1  fetch stalled (hazard or cache stall); freezes pred_taken_q and lookup counter
mispredict  input  1  EX resolved a wrong prediction; redirect this cycle
redirect_pc  input  32  correct PC when mispredict=1
upd_valid  input  1  EX resolved a control-transfer instruction this cycle
upd_pc  input  32  PC of the resolved instruction
upd_taken  input  1  resolved direction (jumps report 1)
upd_target  input  32  resolved target address
next_pc  output  32  value for the PC register's new-PC input
pred_taken  output  1  combinational: current PC predicted taken
pred_taken_q  output  1  registered prediction aligned with the IF/ID instruction
stat_lookups  output  32  count of non-stalled lookup cycles
stat_mispredicts  output  32  count of mispredict cycles

Behaviour:
- Entry contents: valid, tag[TAG_W], target[32], ctr[2]. pc[1:0] ignored for index/tag.
- Reset (rst=1 at edge): all valid=0, ctr=2'b00, pred_taken_q=0, stat_lookups=0, stat_mispredicts=0. Reset takes priority over every other input. Reset mid-training discards the pending update. Lookups after reset all miss.
- Lookup is combinational from pc_in:
  - hit = valid[idx] && tag[idx]==pc_in tag.
  - pred_taken = hit && ctr[idx][1].
- next_pc priority:
  1. mispredict -> redirect_pc.
  2. pred_taken -> target[idx].
  3. otherwise pc_in+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- next_pc is computed regardless of stall; the PC register decides whether to load.
- Update (upd_valid=1), written at the clock edge:
  - Tag hit at upd_pc index:
    - ctr saturating +1 if upd_taken, saturating -1 otherwise (bounds 0 and 3).
    - If upd_taken, target overwritten with upd_target.
  - Miss, upd_taken=1: allocate/replace; valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10.
  - Miss, upd_taken=0: no change.
- Simultaneous lookup and update of the same index: the lookup uses pre-update contents. The new contents are visible from the next cycle (no bypass).
- pred_taken_q:
  - mispredict=1 -> cleared to 0 (the squashed fetch carries no prediction). Mispredict overrides stall.
  - else stall=0 -> loads pred_taken.
  - else holds.
- stat_lookups: +1 each cycle with stall=0 and rst=0.
- stat_mispredicts: +1 each cycle with mispredict=1, independent of stall.
- Both counters wrap at 2^32.
- upd_valid and mispredict are independent; both may assert in the same cycle and are applied together.
- Update occurs even while stall=1.

Test Plan:
- Reset, pc_in=0x00000100 -> next_pc=0x00000104, pred_taken=0, pred_taken_q=0, both stats 0 after reset.
- Update upd_pc=0x40, taken=1, target=0x80, then pc_in=0x40 -> pred_taken=1, next_pc=0x80. Same cycle as the update, pc_in=0x40 -> next_pc=0x44.
- Two not-taken updates at 0x40 after allocation (ctr 10->01->00) -> next_pc=0x44. Three taken updates -> ctr saturates at 11. One not-taken -> still predicts 0x80.
- Aliasing: entry at 0x40, pc_in=0x80 (same index, different tag) -> miss, next_pc=0x84. Not-taken update at 0x80 leaves the 0x40 entry intact.
- mispredict=1, redirect_pc=0x200, with stall=1 and pred_taken=1 -> next_pc=0x200, pred_taken_q=0 next cycle, stat_mispredicts +1, stat_lookups unchanged.
- pc_in=0xFFFFFFFC, empty BTB -> next_pc=0x00000000. Stall held 3 cycles -> pred_taken_q and stat_lookups frozen.
